clk_div_scheduler: RTL

Run-time controller for the radar simulator's divided clock. It replaces a fixed, compile-time divide ratio with a programmable one, sequencing a square-wave OUT_CLK from the system clock. The divide ratio is loaded through a valid/ready handshake and applied only at a period boundary, so OUT_CLK never glitches. Start/stop and burst (N-period) operation are under control of the simulator sequencing logic.

---
 rtl/clk_div_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/clk_div_scheduler.sv
// Programmable divided-clock generator: square-wave OUT_CLK of period 2*CUR_DIV,
// with start/stop, N-period bursts and glitch-free divider updates at period boundaries.
module clk_div_scheduler #(
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 15
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [CNT_WIDTH-1:0] BURST_LEN,
  input  logic [CNT_WIDTH-1:0] DIV_VALUE,
  input  logic                 DIV_VALID,
  output logic                 DIV_READY,
  output logic                 OUT_CLK,
  output logic                 OUT_TICK,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CNT_WIDTH-1:0] CUR_DIV
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_STOPPING = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DIV_RST = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cur_div_q, cur_div_d;
  logic [CNT_WIDTH-1:0] pend_val_q, pend_val_d;
  logic                 pend_q, pend_d;
  logic [CNT_WIDTH-1:0] half_q, half_d;
  logic [CNT_WIDTH-1:0] per_q, per_d;
  logic [CNT_WIDTH-1:0] burst_q, burst_d;
  logic                 out_clk_q, out_clk_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic                 div_accept;
  logic [CNT_WIDTH-1:0] div_clamped;
  logic                 half_end;
  logic                 low_end;
  logic [CNT_WIDTH-1:0] per_inc;
  logic                 burst_hit;

  assign div_accept  = DIV_VALID && !pend_q;
  assign div_clamped = (DIV_VALUE == '0) ? ONE : DIV_VALUE;
  assign half_end    = (half_q == (cur_div_q - ONE));
  assign low_end     = half_end && !out_clk_q;
  // Period count saturates so long continuous runs never wrap into a false burst match.
  assign per_inc     = (per_q == CNT_MAX) ? per_q : (per_q + ONE);
  assign burst_hit   = (burst_q != '0) && (per_inc == burst_q);

  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    half_d     = half_q;
    per_d      = per_q;
    burst_d    = burst_q;
    out_clk_d  = out_clk_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (div_accept) begin
          cur_div_d = div_clamped;
        end
        if (START && !STOP) begin
          state_d   = S_RUN;
          out_clk_d = 1'b1;
          tick_d    = 1'b1;
          half_d    = '0;
          per_d     = '0;
          burst_d   = BURST_LEN;
        end
      end

      S_RUN, S_STOPPING: begin
        if (half_end) begin
          half_d    = '0;
          out_clk_d = 1'b0;
        end else begin
          half_d = half_q + ONE;
        end

        if (low_end) begin
          per_d = per_inc;
          if ((state_q == S_STOPPING) || STOP || burst_hit) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            out_clk_d = 1'b0;
            pend_d    = 1'b0;
            // A write still pending (or arriving right now) takes effect as the run ends.
            if (pend_q) begin
              cur_div_d = pend_val_q;
            end else if (div_accept) begin
              cur_div_d = div_clamped;
            end
          end else begin
            out_clk_d = 1'b1;
            tick_d    = 1'b1;
            if (pend_q) begin
              cur_div_d = pend_val_q;
              pend_d    = 1'b0;
            end else if (div_accept) begin
              pend_d     = 1'b1;
              pend_val_d = div_clamped;
            end
          end
        end else begin
          if (div_accept) begin
            pend_d     = 1'b1;
            pend_val_d = div_clamped;
          end
          if (STOP) begin
            state_d = S_STOPPING;
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        out_clk_d = 1'b0;
        pend_d    = 1'b0;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = !pend_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cur_div_q  <= DIV_RST;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      half_q     <= '0;
      per_q      <= '0;
      burst_q    <= '0;
      out_clk_q  <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      half_q     <= half_d;
      per_q      <= per_d;
      burst_q    <= burst_d;
      out_clk_q  <= out_clk_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign DIV_READY = ready_q;
  assign OUT_CLK   = out_clk_q;
  assign OUT_TICK  = tick_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CUR_DIV   = cur_div_q;

endmodule
